// File: rtl/mul_pkg.sv
// mul_pkg: shared width defaults and elaboration helpers for the
// sequential shift-and-add multiplier (mul, mul_step).
package mul_pkg;

    localparam int MUL_BW_CNT_DEF    = 2;
    localparam int MUL_BW_MCAND_DEF  = 3;
    localparam int MUL_BW_MPLIER_DEF = 4;

    // Smallest counter width n with 2^n > bw_mplier-1 (at least 1 bit).
    function automatic int mul_min_bw_cnt(input int bw_mplier);
        int n;
        n = 1;
        while ((1 << n) <= (bw_mplier - 1))
            n++;
        return n;
    endfunction

endpackage

// File: rtl/mul_step.sv
// mul_step: one combinational shift-and-add step of the multiplier.
// Ports: X (multiplicand), R (accumulator {hi,lo}), R_NXT (stepped R).
import mul_pkg::*;

module mul_step #(
    parameter int BW_MCAND  = MUL_BW_MCAND_DEF,
    parameter int BW_MPLIER = MUL_BW_MPLIER_DEF
) (
    input  logic [BW_MCAND-1:0]           X,
    input  logic [BW_MCAND+BW_MPLIER-1:0] R,
    output logic [BW_MCAND+BW_MPLIER-1:0] R_NXT
);

    localparam int BW_P = BW_MCAND + BW_MPLIER;

    logic [BW_MCAND:0] sum;

    // Add X into the high half when the current multiplier bit is set.
    always_comb begin
        sum = {1'b0, R[BW_P-1:BW_MPLIER]};
        if (R[0])
            sum = sum + {1'b0, X};
    end

    // Shift right by one: sum lands on top, consumed bit drops out.
    generate
        if (BW_MPLIER > 1) begin : g_shift
            assign R_NXT = {sum, R[BW_MPLIER-1:1]};
        end else begin : g_single
            assign R_NXT = sum;
        end
    endgenerate

endmodule

// File: rtl/mul.sv
// mul: sequential unsigned shift-and-add multiplier, one multiplier bit
// per clock, START/BUSY/CLR handshake. Optional build macro MUL_ADDEND_EN
// adds the ADDEND port and makes the block a multiply-add.
// Ports: RSTX, CLK, CLR, MCAND, MPLIER, [ADDEND], START, PROD, BUSY, DONE.
import mul_pkg::*;

module mul #(
    parameter int BW_CNT    = MUL_BW_CNT_DEF,
    parameter int BW_MCAND  = MUL_BW_MCAND_DEF,
    parameter int BW_MPLIER = MUL_BW_MPLIER_DEF
) (
    input  logic                          RSTX,
    input  logic                          CLK,
    input  logic                          CLR,
    input  logic [BW_MCAND-1:0]           MCAND,
    input  logic [BW_MPLIER-1:0]          MPLIER,
`ifdef MUL_ADDEND_EN
    input  logic [BW_MCAND-1:0]           ADDEND,
`endif
    input  logic                          START,
    output logic [BW_MCAND+BW_MPLIER-1:0] PROD,
    output logic                          BUSY,
    output logic                          DONE
);

    localparam int BW_P = BW_MCAND + BW_MPLIER;
    localparam logic [BW_CNT-1:0] CNT_LOAD = BW_CNT'(BW_MPLIER - 1);
    localparam logic [BW_CNT-1:0] CNT_ONE  = BW_CNT'(1);
    localparam logic              ONE_STEP = (BW_MPLIER == 1);

    generate
        if (BW_CNT < mul_min_bw_cnt(BW_MPLIER)) begin : g_bad_cnt
            $error("mul: BW_CNT too small for BW_MPLIER");
        end
    endgenerate

    logic [BW_CNT-1:0]   cnt;
    logic [BW_MCAND-1:0] mcand_r;
    logic [BW_P-1:0]     acc;
    logic                done_r;

    logic [BW_MCAND-1:0] step_x;
    logic [BW_P-1:0]     step_r;
    logic [BW_P-1:0]     step_nxt;
    logic [BW_P-1:0]     start_r;

`ifdef MUL_ADDEND_EN
    assign start_r = {ADDEND, MPLIER};
`else
    assign start_r = {{BW_MCAND{1'b0}}, MPLIER};
`endif

    // The START cycle performs the first step straight from the ports,
    // so the result is ready BW_MPLIER edges after START.
    assign step_x = START ? MCAND   : mcand_r;
    assign step_r = START ? start_r : acc;

    mul_step #(
        .BW_MCAND  (BW_MCAND),
        .BW_MPLIER (BW_MPLIER)
    ) u_step (
        .X     (step_x),
        .R     (step_r),
        .R_NXT (step_nxt)
    );

    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            cnt     <= '0;
            mcand_r <= '0;
            acc     <= '0;
            done_r  <= 1'b0;
        end else if (CLR) begin
            cnt    <= '0;
            acc    <= '0;
            done_r <= 1'b0;
        end else if (START) begin
            acc     <= step_nxt;
            mcand_r <= MCAND;
            cnt     <= CNT_LOAD;
            done_r  <= ONE_STEP;
        end else if (cnt != '0) begin
            acc    <= step_nxt;
            cnt    <= cnt - CNT_ONE;
            done_r <= (cnt == CNT_ONE);
        end else begin
            done_r <= 1'b0;
        end
    end

    assign PROD = acc;
    assign BUSY = (cnt != '0);
    assign DONE = done_r;

endmodule

// File: tb/tb_mul.sv
// tb_mul: self-checking bench for mul; random and directed stimulus
// against a cycle-level behavioural model of the multiplier.
module tb_mul;

    localparam int BW_MCAND  = 3;
    localparam int BW_MPLIER = 4;
    localparam int BW_P      = BW_MCAND + BW_MPLIER;
`ifdef MUL_ADDEND_EN
    localparam bit ADD_EN = 1'b1;
`else
    localparam bit ADD_EN = 1'b0;
`endif

    logic                 RSTX;
    logic                 CLK;
    logic                 CLR;
    logic [BW_MCAND-1:0]  MCAND;
    logic [BW_MPLIER-1:0] MPLIER;
    logic [BW_MCAND-1:0]  ADDEND;
    logic                 START;
    logic [BW_P-1:0]      PROD;
    logic                 BUSY;
    logic                 DONE;

    int checks;
    int failures;

    // model state: edges still to go, pending result, visible outputs
    int m_left;
    int m_target;
    int m_prod;
    bit m_done;
    int n_done;

    mul #(
        .BW_CNT    (2),
        .BW_MCAND  (BW_MCAND),
        .BW_MPLIER (BW_MPLIER)
    ) dut (
        .RSTX   (RSTX),
        .CLK    (CLK),
        .CLR    (CLR),
        .MCAND  (MCAND),
        .MPLIER (MPLIER),
`ifdef MUL_ADDEND_EN
        .ADDEND (ADDEND),
`endif
        .START  (START),
        .PROD   (PROD),
        .BUSY   (BUSY),
        .DONE   (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_left   = 0;
        m_target = 0;
        m_prod   = 0;
        m_done   = 0;
    endtask

    // One clock: drive inputs, advance the model at the edge, compare.
    task automatic cyc(input bit s, input bit c,
                       input int a, input int b, input int d);
        START  = s;
        CLR    = c;
        MCAND  = BW_MCAND'(a);
        MPLIER = BW_MPLIER'(b);
        ADDEND = BW_MCAND'(d);
        @(posedge CLK);
        if (c) begin
            m_left = 0;
            m_prod = 0;
            m_done = 0;
        end else if (s) begin
            m_target = a * b + (ADD_EN ? d : 0);
            m_left   = BW_MPLIER - 1;
            m_done   = (m_left == 0);
            if (m_left == 0)
                m_prod = m_target;
        end else if (m_left > 0) begin
            m_left--;
            m_done = (m_left == 0);
            if (m_left == 0)
                m_prod = m_target;
        end else begin
            m_done = 0;
        end
        #1;
        check("busy", int'(BUSY), int'(m_left != 0));
        check("done", int'(DONE), int'(m_done));
        if (m_left == 0)
            check("prod", int'(PROD), m_prod);
        if (DONE)
            n_done++;
        START = 1'b0;
        CLR   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc(1'b0, 1'b0, 0, 0, 0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        n_done   = 0;
        RSTX   = 1'b0;
        CLR    = 1'b0;
        START  = 1'b0;
        MCAND  = '0;
        MPLIER = '0;
        ADDEND = '0;
        model_reset();
        #12;
        check("rst_prod", int'(PROD), 0);
        check("rst_busy", int'(BUSY), 0);
        check("rst_done", int'(DONE), 0);
        @(negedge CLK);
        RSTX = 1'b1;
        @(posedge CLK);
        #1;

        // 7 x 15: BUSY three cycles, then DONE with the product
        cyc(1'b1, 1'b0, 7, 15, 0);
        check("b0_busy", int'(BUSY), 1);
        idle(2);
        check("b2_busy", int'(BUSY), 1);
        idle(1);
        check("d7x15_done", int'(DONE), 1);
        check("d7x15_prod", int'(PROD), 105 + (ADD_EN ? 0 : 0));
        idle(1);
        check("d7x15_once", int'(DONE), 0);

        // zero operands
        cyc(1'b1, 1'b0, 0, 9, 0);
        idle(3);
        check("d0x9", int'(PROD), 0);
        cyc(1'b1, 1'b0, 5, 0, 0);
        idle(3);
        check("d5x0", int'(PROD), 0);

        // restart while busy: only one DONE, four edges after restart
        cyc(1'b1, 1'b0, 3, 4, 0);
        n_done = 0;
        cyc(1'b1, 1'b0, 6, 11, 0);
        idle(3);
        check("rs_done", int'(DONE), 1);
        check("rs_prod", int'(PROD), 66);
        idle(2);
        check("rs_ndone", n_done, 1);

        // CLR mid-operation
        n_done = 0;
        cyc(1'b1, 1'b0, 7, 15, 0);
        idle(1);
        cyc(1'b0, 1'b1, 0, 0, 0);
        check("clr_busy", int'(BUSY), 0);
        check("clr_prod", int'(PROD), 0);
        idle(4);
        check("clr_ndone", n_done, 0);

        // START together with CLR: CLR wins
        cyc(1'b1, 1'b1, 7, 15, 0);
        check("sc_busy", int'(BUSY), 0);

        // back-to-back: next START in the DONE cycle
        cyc(1'b1, 1'b0, 2, 3, 0);
        idle(3);
        check("bb_prod0", int'(PROD), 6);
        check("bb_done0", int'(DONE), 1);
        cyc(1'b1, 1'b0, 5, 13, 0);
        idle(3);
        check("bb_prod1", int'(PROD), 65);
        check("bb_done1", int'(DONE), 1);

`ifdef MUL_ADDEND_EN
        cyc(1'b1, 1'b0, 7, 15, 7);
        idle(3);
        check("ad_7x15p7", int'(PROD), 112);
        cyc(1'b1, 1'b0, 5, 13, 2);
        idle(3);
        check("ad_5x13p2", int'(PROD), 67);
`endif

        // asynchronous reset mid-operation
        cyc(1'b1, 1'b0, 6, 7, 3);
        idle(1);
        #3;
        RSTX = 1'b0;
        #1;
        check("ar_prod", int'(PROD), 0);
        check("ar_busy", int'(BUSY), 0);
        check("ar_done", int'(DONE), 0);
        model_reset();
        #1;
        RSTX = 1'b1;

        // random traffic
        for (int i = 0; i < 600; i++) begin
            bit s;
            bit c;
            s = ($urandom_range(3) == 0);
            c = ($urandom_range(31) == 0);
            cyc(s, c, int'($urandom_range(7)), int'($urandom_range(15)),
                int'($urandom_range(7)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
